// File: rtl/cache_mem_arbiter_if.sv
// Cache-side port bundle: one instance per cache between its mem_system and the memory arbiter.
// The cache drives the request half (master); the arbiter drives grant and read return (slave).
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              valid;

  modport master (output req, rd, wr, addr, wdata, input gnt, rdata, valid);
  modport slave  (input req, rd, wr, addr, wdata, output gnt, rdata, valid);
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares the single four-bank backing memory between I-cache and D-cache line traffic,
// granting one owner at a time and steering each read return to the cache that issued it.
module cache_mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_mem_arbiter_if.slave ic_if,
  cache_mem_arbiter_if.slave dc_if,
  output logic               mem_rd_o,
  output logic               mem_wr_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  input  logic               mem_stall_i,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, OWN_IC, OWN_DC, DRAIN} state_e;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;
  localparam int   TAIL     = MEM_LAT - 1;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [MEM_LAT-1:0] pipeVld_q, pipeVld_d;
  logic [MEM_LAT-1:0] pipeOwn_q, pipeOwn_d;
  logic [MEM_LAT-1:0] pipeAhead;

  logic               ownIc, ownDc;
  logic               selReq, selRd, selWr;
  logic [ADDR_W-1:0]  selAddr;
  logic [DATA_W-1:0]  selWdata;
  logic               issue;
  logic               retVld, icRet, dcRet;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= OWNER_IC;
      pipeVld_q <= '0;
      pipeOwn_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      pipeVld_q <= pipeVld_d;
      pipeOwn_q <= pipeOwn_d;
    end
  end

  // pipeAhead holds only reads still behind the tail, so DRAIN can leave as the last one returns.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    pipeAhead    = pipeVld_q << 1;
    pipeVld_d    = pipeAhead;
    pipeOwn_d    = pipeOwn_q << 1;
    pipeVld_d[0] = mem_rd_o;
    pipeOwn_d[0] = ownDc;
    case (state_q)
      IDLE: begin
        if (dc_if.req && (!ic_if.req || last_q == OWNER_IC)) begin
          state_d = OWN_DC;
          last_d  = OWNER_DC;
        end else if (ic_if.req) begin
          state_d = OWN_IC;
          last_d  = OWNER_IC;
        end
      end
      OWN_IC: begin
        if (!ic_if.req) state_d = (pipeVld_q == '0) ? IDLE : DRAIN;
      end
      OWN_DC: begin
        if (!dc_if.req) state_d = (pipeVld_q == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (pipeAhead == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst_n is low so nothing leaks before the reset edge settles state.
  always_comb begin
    ownIc    = rst_n && (state_q == OWN_IC);
    ownDc    = rst_n && (state_q == OWN_DC);
    selReq   = 1'b0;
    selRd    = 1'b0;
    selWr    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    if (ownIc) begin
      selReq   = ic_if.req;
      selRd    = ic_if.rd;
      selWr    = ic_if.wr;
      selAddr  = ic_if.addr;
      selWdata = ic_if.wdata;
    end else if (ownDc) begin
      selReq   = dc_if.req;
      selRd    = dc_if.rd;
      selWr    = dc_if.wr;
      selAddr  = dc_if.addr;
      selWdata = dc_if.wdata;
    end

    err_o       = (selRd && selWr) || ((selRd || selWr) && selAddr[0]);
    issue       = selReq && (selRd || selWr) && !mem_stall_i && !err_o;
    ic_if.gnt   = issue && ownIc;
    dc_if.gnt   = issue && ownDc;
    mem_rd_o    = issue && selRd;
    mem_wr_o    = issue && selWr;
    mem_addr_o  = selAddr;
    mem_wdata_o = selWdata;

    retVld      = rst_n && pipeVld_q[TAIL];
    icRet       = retVld && (pipeOwn_q[TAIL] == OWNER_IC);
    dcRet       = retVld && (pipeOwn_q[TAIL] == OWNER_DC);
    ic_if.valid = icRet;
    dc_if.valid = dcRet;
    ic_if.rdata = icRet ? mem_rdata_i : '0;
    dc_if.rdata = dcRet ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed per-cycle vectors for the cache/memory arbiter: reset, line reads, contention with
// drain, owner errors, stall retry and reset with reads in flight.
module tb_cache_mem_arbiter;

  localparam int MEM_LAT = 2;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              memRd, memWr, err;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata, memRdata;
  logic              memStall;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) icBus ();
  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dcBus ();

  cache_mem_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ic_if       (icBus),
    .dc_if       (dcBus),
    .mem_rd_o    (memRd),
    .mem_wr_o    (memWr),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_rdata_i (memRdata),
    .mem_stall_i (memStall),
    .err_o       (err)
  );

  typedef struct {
    logic        rstN;
    logic        icReq, icRd, icWr;
    logic [15:0] icAddr;
    logic        dcReq, dcRd, dcWr;
    logic [15:0] dcAddr;
    logic        stall;
    logic [15:0] rdata;
    logic        eIcGnt, eDcGnt, eIcValid, eDcValid, eMemRd, eMemWr, eErr;
    logic [15:0] eMemAddr;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    input logic rstN, input logic icReq, input logic icRd, input logic icWr, input logic [15:0] icAddr,
    input logic dcReq, input logic dcRd, input logic dcWr, input logic [15:0] dcAddr,
    input logic stall, input logic [15:0] rdata,
    input logic eIcGnt, input logic eDcGnt, input logic eIcValid, input logic eDcValid,
    input logic eMemRd, input logic eMemWr, input logic eErr, input logic [15:0] eMemAddr);
    vec_t v;
    v.rstN = rstN;   v.icReq = icReq; v.icRd = icRd; v.icWr = icWr; v.icAddr = icAddr;
    v.dcReq = dcReq; v.dcRd = dcRd;   v.dcWr = dcWr; v.dcAddr = dcAddr;
    v.stall = stall; v.rdata = rdata;
    v.eIcGnt = eIcGnt; v.eDcGnt = eDcGnt; v.eIcValid = eIcValid; v.eDcValid = eDcValid;
    v.eMemRd = eMemRd; v.eMemWr = eMemWr; v.eErr = eErr; v.eMemAddr = eMemAddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Write data is derived from the address so a write's data can be predicted from its address.
  task automatic applyStimulus(input vec_t v);
    rst_n       = v.rstN;
    icBus.req   = v.icReq;
    icBus.rd    = v.icRd;
    icBus.wr    = v.icWr;
    icBus.addr  = v.icAddr;
    icBus.wdata = v.icAddr ^ 16'hA5A5;
    dcBus.req   = v.dcReq;
    dcBus.rd    = v.dcRd;
    dcBus.wr    = v.dcWr;
    dcBus.addr  = v.dcAddr;
    dcBus.wdata = v.dcAddr ^ 16'hA5A5;
    memStall    = v.stall;
    memRdata    = v.rdata;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    logic [6:0] actCtl, expCtl;
    actCtl = {icBus.gnt, dcBus.gnt, icBus.valid, dcBus.valid, memRd, memWr, err};
    expCtl = {v.eIcGnt, v.eDcGnt, v.eIcValid, v.eDcValid, v.eMemRd, v.eMemWr, v.eErr};
    check({tag, " ctl"}, 32'(actCtl), 32'(expCtl));
    check({tag, " addr"}, 32'(memAddr), 32'(v.eMemAddr));
    check({tag, " ic_rdata"}, 32'(icBus.rdata), 32'(v.eIcValid ? v.rdata : 16'h0000));
    check({tag, " dc_rdata"}, 32'(dcBus.rdata), 32'(v.eDcValid ? v.rdata : 16'h0000));
    if (v.eMemWr) check({tag, " wdata"}, 32'(memWdata), 32'(v.eMemAddr ^ 16'hA5A5));
  endtask

  task automatic step(input vec_t v, input string tag, input bit doCheck);
    @(posedge clk);
    #1;
    applyStimulus(v);
    #4;
    if (doCheck) checkOutput(v, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(mk(0, 0,0,0,16'h0000, 0,0,0,16'h0000, 0,16'h0000, 0,0,0,0,0,0,0,16'h0000));

    // Reset with both requests high, DC wins the first decision, then a 4-word DC line read.
    vecs.push_back(mk(0, 1,1,0,16'h0200, 1,1,0,16'h0100, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000));
    vecs.push_back(mk(0, 1,1,0,16'h0200, 1,1,0,16'h0100, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000));
    vecs.push_back(mk(1, 1,1,0,16'h0200, 1,1,0,16'h0100, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000));
    vecs.push_back(mk(1, 1,1,0,16'h0200, 1,1,0,16'h0100, 0,16'hEEEE, 0,1,0,0,1,0,0,16'h0100));
    vecs.push_back(mk(1, 1,1,0,16'h0200, 1,1,0,16'h0102, 0,16'hEEEE, 0,1,0,0,1,0,0,16'h0102));
    vecs.push_back(mk(1, 1,1,0,16'h0200, 1,1,0,16'h0104, 0,16'hD100, 0,1,0,1,1,0,0,16'h0104));
    vecs.push_back(mk(1, 1,1,0,16'h0200, 1,1,0,16'h0106, 0,16'hD102, 0,1,0,1,1,0,0,16'h0106));
    vecs.push_back(mk(1, 1,1,0,16'h0200, 0,0,0,16'h0106, 0,16'hD104, 0,0,0,1,0,0,0,16'h0106));
    vecs.push_back(mk(1, 1,1,0,16'h0200, 0,0,0,16'h0106, 0,16'hD106, 0,0,0,1,0,0,0,16'h0000));
    vecs.push_back(mk(1, 1,1,0,16'h0200, 0,0,0,16'h0106, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000));
    // IC line while DC waits, drain, then DC again.
    vecs.push_back(mk(1, 1,1,0,16'h0200, 1,1,0,16'h0108, 0,16'hEEEE, 1,0,0,0,1,0,0,16'h0200));
    vecs.push_back(mk(1, 1,1,0,16'h0202, 1,1,0,16'h0108, 0,16'hEEEE, 1,0,0,0,1,0,0,16'h0202));
    vecs.push_back(mk(1, 1,1,0,16'h0204, 1,1,0,16'h0108, 0,16'hC200, 1,0,1,0,1,0,0,16'h0204));
    vecs.push_back(mk(1, 1,1,0,16'h0206, 1,1,0,16'h0108, 0,16'hC202, 1,0,1,0,1,0,0,16'h0206));
    vecs.push_back(mk(1, 0,0,0,16'h0206, 1,1,0,16'h0108, 0,16'hC204, 0,0,1,0,0,0,0,16'h0206));
    vecs.push_back(mk(1, 1,1,0,16'h0208, 1,1,0,16'h0108, 0,16'hC206, 0,0,1,0,0,0,0,16'h0000));
    vecs.push_back(mk(1, 1,1,0,16'h0208, 1,1,0,16'h0108, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000));
    // DC owner: good read, odd address, rd&wr together, read, write, drop with one read pending.
    vecs.push_back(mk(1, 1,1,0,16'h0208, 1,1,0,16'h0108, 0,16'hEEEE, 0,1,0,0,1,0,0,16'h0108));
    vecs.push_back(mk(1, 1,1,0,16'h0208, 1,1,0,16'h0109, 0,16'hEEEE, 0,0,0,0,0,0,1,16'h0109));
    vecs.push_back(mk(1, 1,1,0,16'h0208, 1,1,1,16'h0100, 0,16'hD108, 0,0,0,1,0,0,1,16'h0100));
    vecs.push_back(mk(1, 1,1,0,16'h0208, 1,1,0,16'h010A, 0,16'hEEEE, 0,1,0,0,1,0,0,16'h010A));
    vecs.push_back(mk(1, 1,1,0,16'h0208, 1,0,1,16'h010C, 0,16'hEEEE, 0,1,0,0,0,1,0,16'h010C));
    vecs.push_back(mk(1, 0,0,0,16'h0208, 0,0,0,16'h010C, 0,16'hD10A, 0,0,0,1,0,0,0,16'h010C));
    vecs.push_back(mk(1, 0,0,0,16'h0208, 0,0,0,16'h010C, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000));
    vecs.push_back(mk(1, 0,0,0,16'h0208, 0,0,0,16'h010C, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i), 1'b1);

    // Three stalled cycles mid-line: the held word issues on the first free cycle.
    step(mk(1, 1,0,0,16'h0300, 0,0,0,16'h0000, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000), "s0", 1'b1);
    step(mk(1, 1,1,0,16'h0300, 0,0,0,16'h0000, 0,16'hEEEE, 1,0,0,0,1,0,0,16'h0300), "s1", 1'b1);
    step(mk(1, 1,1,0,16'h0302, 0,0,0,16'h0000, 1,16'hEEEE, 0,0,0,0,0,0,0,16'h0302), "s2", 1'b1);
    step(mk(1, 1,1,0,16'h0302, 0,0,0,16'h0000, 1,16'hC300, 0,0,1,0,0,0,0,16'h0302), "s3", 1'b1);
    step(mk(1, 1,1,0,16'h0302, 0,0,0,16'h0000, 1,16'hEEEE, 0,0,0,0,0,0,0,16'h0302), "s4", 1'b1);
    step(mk(1, 1,1,0,16'h0302, 0,0,0,16'h0000, 0,16'hEEEE, 1,0,0,0,1,0,0,16'h0302), "s5", 1'b1);
    step(mk(1, 1,0,0,16'h0302, 0,0,0,16'h0000, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0302), "s6", 1'b1);
    step(mk(1, 0,0,0,16'h0302, 0,0,0,16'h0000, 0,16'hC302, 0,0,1,0,0,0,0,16'h0302), "s7", 1'b1);
    step(mk(1, 0,0,0,16'h0302, 0,0,0,16'h0000, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000), "s8", 1'b1);

    // Reset one cycle after two reads issue: their returns must never appear.
    step(mk(1, 0,0,0,16'h0000, 1,0,0,16'h0400, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000), "r0", 1'b1);
    step(mk(1, 0,0,0,16'h0000, 1,1,0,16'h0400, 0,16'hEEEE, 0,1,0,0,1,0,0,16'h0400), "r1", 1'b1);
    step(mk(1, 0,0,0,16'h0000, 1,1,0,16'h0402, 0,16'hEEEE, 0,1,0,0,1,0,0,16'h0402), "r2", 1'b1);
    step(mk(0, 0,0,0,16'h0000, 1,1,0,16'h0404, 0,16'hD400, 0,0,0,0,0,0,0,16'h0000), "r3", 1'b0);
    step(mk(1, 0,0,0,16'h0000, 1,1,0,16'h0404, 0,16'hD402, 0,0,0,0,0,0,0,16'h0000), "r4", 1'b1);
    step(mk(1, 0,0,0,16'h0000, 1,0,0,16'h0404, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0404), "r5", 1'b1);
    step(mk(1, 0,0,0,16'h0000, 0,0,0,16'h0404, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0404), "r6", 1'b1);
    step(mk(1, 0,0,0,16'h0000, 0,0,0,16'h0404, 0,16'hEEEE, 0,0,0,0,0,0,0,16'h0000), "r7", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
